feat_frame_driver: RTL and testbench
====================================

FEAT_FRAME_DRIVER -- requirements
Module: feat_frame_driver

Interface
REQ-001 SHALL have parameter FEAT_W, default 10, meaning bit width of each feature word.
REQ-002 SHALL have parameter EVAL_LAT, default 1, meaning settle cycles (range 1..15) allowed for the downstream classifier before its decision is sampled.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  FEAT_W  feature word; order within a frame is feat_1, feat_2, feat_3.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1) as the word handshake.
REQ-007 SHALL have ports feat_1, feat_2, feat_3  output  FEAT_W  each; these drive the classifier feature inputs.
REQ-008 SHALL have port decision  input  3  one-hot class vector returned by the classifier.
REQ-009 SHALL have port res_class  output  2  encoded class index, with 3 meaning invalid.
REQ-010 SHALL have port res_err  output  1  flag, set when the sampled decision is not exactly one-hot.
REQ-011 SHALL have ports res_valid (output, 1) and res_ready (input, 1) as the result handshake.
REQ-012 SHALL have port frame_cnt  output  16  count of completed result handshakes.

Function
REQ-013 SHALL implement FSM states LOAD, EVAL, OUT.
REQ-014 In LOAD: in_ready=1; a word transfers when in_valid&in_ready; the word index advances 0->1->2.
- Index 0 writes feat_1, index 1 writes feat_2, index 2 writes feat_3.
REQ-015 Transfer of index 2 SHALL move the FSM to EVAL on the next cycle and clear the index to 0.
REQ-016 feat_1..3 SHALL be registered outputs, changing only on their own accepted word, and holding through EVAL and OUT.
REQ-017 In EVAL: in_ready=0; a settle counter loads EVAL_LAT on entry and decrements each cycle.
- When the counter reaches 1, decision SHALL be sampled on that edge and the FSM SHALL enter OUT.
REQ-018 Latency: if the last word is accepted at edge N, res_valid SHALL rise after edge N+EVAL_LAT.
REQ-019 Decode: 001->0, 010->1, 100->2, with res_err=0; any other value (including 000 and multi-hot) SHALL give res_class=3 and res_err=1.
REQ-020 In OUT: res_valid=1 and in_ready=0; res_class and res_err SHALL stay stable until res_valid&res_ready.
REQ-021 On the result handshake SHALL:
- return to LOAD;
- deassert res_valid next cycle;
- increment frame_cnt.
REQ-022 frame_cnt SHALL wrap 65535->0 with no flag.
REQ-023 res_ready asserted outside OUT SHALL have no effect; in_valid outside LOAD SHALL have no effect, and the word is not consumed.
REQ-024 decision changes outside the sample edge SHALL be ignored.
REQ-025 in_ready SHALL be a registered or state-decoded signal with no combinational path from in_valid or res_ready.

Reset
REQ-026 RST low SHALL immediately set:
- state=LOAD, index=0, settle counter=0;
- feat_1..3=0;
- res_class=0, res_err=0, res_valid=0;
- frame_cnt=0.
REQ-027 in_ready SHALL be 0 while RST is low and 1 from the first edge after RST deasserts.
REQ-028 Reset mid-frame or mid-OUT SHALL discard the partial frame or pending result; the next accepted word is feat_1.

Verification
REQ-029 Words 200,100,0 with classifier model attached -> decision 001; res_class=0, res_err=0; res_valid rises EVAL_LAT edges after the third accept; frame_cnt=1 after handshake.
REQ-030 Frames (400,0,0), (300,0,700), (300,0,500), (250,800,0) -> res_class 1,1,2,2 in order; frame_cnt=4.
REQ-031 res_ready held low 5 cycles in OUT while in_valid=1 -> res_valid and res_class stable, in_ready=0, no word consumed; first word after the handshake lands in feat_1.
REQ-032 Bench forces decision=011, then 000 at the sample edge -> res_class=3, res_err=1 for both.
REQ-033 RST pulsed low after 2 words accepted -> all outputs 0 asynchronously; a following frame 200,100,0 yields res_class=0 and frame_cnt=1.
REQ-034 Preset frame_cnt near wrap: 65536 consecutive frames -> frame_cnt returns to 0; EVAL_LAT=4 build -> latency rule of REQ-018 holds.

Source files
------------

// File: rtl/feat_frame_driver_if.sv
// Bundle of the word-in, feature-out and result handshake signals of the
// feature frame driver. The slave modport is the driver's own view; the
// master modport is the view of whatever feeds words and consumes results.
interface feat_frame_driver_if #(
  parameter int FEAT_W = 10
);
  logic [FEAT_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [FEAT_W-1:0] feat_1;
  logic [FEAT_W-1:0] feat_2;
  logic [FEAT_W-1:0] feat_3;
  logic [2:0]        decision;
  logic [1:0]        res_class;
  logic              res_err;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       frame_cnt;

  modport slave (
    input  in_data, in_valid, decision, res_ready,
    output in_ready, feat_1, feat_2, feat_3,
           res_class, res_err, res_valid, frame_cnt
  );

  modport master (
    output in_data, in_valid, decision, res_ready,
    input  in_ready, feat_1, feat_2, feat_3,
           res_class, res_err, res_valid, frame_cnt
  );
endinterface

// File: rtl/feat_frame_driver.sv
// Feature frame driver: gathers three feature words into registered
// classifier inputs, waits EVAL_LAT cycles for the classifier to settle,
// samples and encodes its one-hot decision, and offers the encoded class
// on a valid/ready result handshake while counting completed frames.
module feat_frame_driver #(
  parameter int FEAT_W   = 10,
  parameter int EVAL_LAT = 1
) (
  input logic                CLK,
  input logic                RST,
  feat_frame_driver_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] cls;
    logic       err;
  } result_t;

  localparam logic [3:0] SETTLE_INIT = 4'(EVAL_LAT);

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic [1:0]        idx_q;
  logic [3:0]        settle_q;
  logic [FEAT_W-1:0] feat_1_q, feat_2_q, feat_3_q;
  result_t           res_q, dec_res;
  logic [15:0]       frame_cnt_q;

  logic word_xfer;
  logic last_word;
  logic res_xfer;
  logic sample_now;

  // in_ready_q is only ever high in LOAD, so no extra state qualifier is needed
  assign word_xfer  = bus.in_valid & in_ready_q;
  assign last_word  = word_xfer & (idx_q == 2'd2);
  assign res_xfer   = (state_q == OUT) & bus.res_ready;
  assign sample_now = (state_q == EVAL) & (settle_q <= 4'd1);

  // Encode the classifier's one-hot decision; anything not exactly one-hot is invalid
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    dec_res = '{cls: 2'd3, err: 1'b1};
    case (bus.decision)
      3'b001:  dec_res = '{cls: 2'd0, err: 1'b0};
      3'b010:  dec_res = '{cls: 2'd1, err: 1'b0};
      3'b100:  dec_res = '{cls: 2'd2, err: 1'b0};
      default: ;
    endcase
  end

  // Next-state logic: collect three words, settle, then hold the result until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_word)  state_d = EVAL;
      EVAL:    if (sample_now) state_d = OUT;
      OUT:     if (res_xfer)   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // State register; in_ready is registered from the next state so it stays low in reset
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: registers use non-blocking assignments so every flop sees pre-edge values regardless of block order.
    if (!RST) begin
      state_q    <= LOAD;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == LOAD);
    end
  end

  // Word index within the frame and the classifier settle counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q    <= 2'd0;
      settle_q <= 4'd0;
    end else begin
      if (word_xfer) begin
        idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      if (last_word) begin
        settle_q <= SETTLE_INIT;
      end else if ((state_q == EVAL) && (settle_q != 4'd0)) begin
        settle_q <= settle_q - 4'd1;
      end
    end
  end

  // Feature registers: each one changes only when its own word is accepted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      feat_1_q <= '0;
      feat_2_q <= '0;
      feat_3_q <= '0;
    end else if (word_xfer) begin
      case (idx_q)
        2'd0:    feat_1_q <= bus.in_data;
        2'd1:    feat_2_q <= bus.in_data;
        2'd2:    feat_3_q <= bus.in_data;
        default: ;
      endcase
    end
  end

  // Result register: the decision is captured only on the final settle edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_q <= '{cls: 2'd0, err: 1'b0};
    end else if (sample_now) begin
      res_q <= dec_res;
    end
  end

  // Completed-frame counter, wrapping silently at 16 bits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt_q <= 16'd0;
    end else if (res_xfer) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.feat_1    = feat_1_q;
  assign bus.feat_2    = feat_2_q;
  assign bus.feat_3    = feat_3_q;
  assign bus.res_class = res_q.cls;
  assign bus.res_err   = res_q.err;
  assign bus.res_valid = (state_q == OUT);
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_feat_frame_driver.sv
// Self-checking bench for feat_frame_driver: a table of frames with known
// classes, hand-written stall/reset/wrap sequences, randomized frames checked
// against a reference decoder, and a second instance with EVAL_LAT=4.
module tb_feat_frame_driver;

  localparam int FEAT_W = 10;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 4;
  localparam int BUDGET = 64;

  typedef logic [FEAT_W-1:0] word_t;

  typedef struct {
    string      name;
    word_t      w1, w2, w3;
    logic       ovr;
    logic [2:0] dec;
    logic [1:0] cls;
    logic       err;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cnt = 0;
  logic        ovr_en = 1'b0;
  logic [2:0]  ovr_val = 3'b000;
  vec_t        tbl[11];

  feat_frame_driver_if #(.FEAT_W(FEAT_W)) bus ();
  feat_frame_driver_if #(.FEAT_W(FEAT_W)) bus_b ();

  feat_frame_driver #(.FEAT_W(FEAT_W), .EVAL_LAT(LAT_A)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  feat_frame_driver #(.FEAT_W(FEAT_W), .EVAL_LAT(LAT_B)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in classifier: a small fixed decision tree over the three features
  function automatic int classify(input word_t f1, input word_t f2, input word_t f3);
    if (f1 == 10'd1023) return 0;
    if (f2 > 10'd500) return 2;
    if (f2 != 10'd0) return 0;
    if ((f3 == 10'd0) || (f3 > 10'd600)) return 1;
    return 2;
  endfunction

  always_comb begin
    bus.decision = 3'b001 << classify(bus.feat_1, bus.feat_2, bus.feat_3);
    if (ovr_en) bus.decision = ovr_val;
  end

  always_comb bus_b.decision = 3'b001 << classify(bus_b.feat_1, bus_b.feat_2, bus_b.feat_3);

  // Reference decoder: position of the single set bit, otherwise invalid
  function automatic void ref_decode(input logic [2:0] d, output logic [1:0] cls,
                                     output logic err);
    cls = 2'd3;
    err = 1'b1;
    if ($countones(d) == 1) begin
      err = 1'b0;
      for (int i = 0; i < 3; i++) if (d[i]) cls = 2'(i);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within %0d cycles", name, BUDGET);
  endtask

  // Offer one word from a negedge; returns the edge count at which it was accepted
  task automatic push_word(input word_t w, output int unsigned edge_n);
    int k;
    k = 0;
    edge_n = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < BUDGET) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.in_ready) begin
      timeout("push_word");
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      edge_n = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, check latency/class, optionally stall, then take it
  task automatic finish_frame(input string name, input int unsigned n, input word_t w1,
                              input logic [1:0] cls, input logic err, input int stall);
    int k;
    logic       sv_en;
    logic [2:0] sv_val;
    k = 0;
    while (!bus.res_valid && k < BUDGET) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.res_valid) begin
      timeout({name, ".res_valid"});
    end else begin
      check({name, ".latency"}, 32'(cyc - n), 32'(LAT_A));
      check({name, ".res_class"}, 32'(bus.res_class), 32'(cls));
      check({name, ".res_err"}, 32'(bus.res_err), 32'(err));
      sv_en  = ovr_en;
      sv_val = ovr_val;
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = word_t'($urandom);
        ovr_en       = 1'b1;
        ovr_val      = 3'($urandom);
        @(negedge CLK);
        check({name, ".stall_valid"}, 32'(bus.res_valid), 32'd1);
        check({name, ".stall_class"}, 32'(bus.res_class), 32'(cls));
        check({name, ".stall_err"}, 32'(bus.res_err), 32'(err));
        check({name, ".stall_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, ".stall_feat_1"}, 32'(bus.feat_1), 32'(w1));
      end
      bus.in_valid  = 1'b0;
      ovr_en        = sv_en;
      ovr_val       = sv_val;
      bus.res_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      bus.res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 65536;
      check({name, ".frame_cnt"}, 32'(bus.frame_cnt), exp_cnt);
      check({name, ".valid_drop"}, 32'(bus.res_valid), 32'd0);
    end
  endtask

  task automatic run_frame(input string name, input word_t w1, input word_t w2, input word_t w3,
                           input logic [1:0] cls, input logic err, input int stall);
    int unsigned n;
    push_word(w1, n);
    push_word(w2, n);
    push_word(w3, n);
    check({name, ".feat_1"}, 32'(bus.feat_1), 32'(w1));
    check({name, ".feat_2"}, 32'(bus.feat_2), 32'(w2));
    check({name, ".feat_3"}, 32'(bus.feat_3), 32'(w3));
    finish_frame(name, n, w1, cls, err, stall);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, ".res_valid"}, 32'(bus.res_valid), 32'd0);
    check({name, ".res_class"}, 32'(bus.res_class), 32'd0);
    check({name, ".res_err"}, 32'(bus.res_err), 32'd0);
    check({name, ".frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
    check({name, ".feat_1"}, 32'(bus.feat_1), 32'd0);
    check({name, ".feat_2"}, 32'(bus.feat_2), 32'd0);
    check({name, ".feat_3"}, 32'(bus.feat_3), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, nb;
    word_t       w1, w2, w3;
    word_t       wb[3];
    logic [1:0]  ecls;
    logic        eerr;
    int          k;

    tbl[0]  = '{"req029",    10'd200, 10'd100, 10'd0,   1'b0, 3'b000, 2'd0, 1'b0};
    tbl[1]  = '{"req030_a",  10'd400, 10'd0,   10'd0,   1'b0, 3'b000, 2'd1, 1'b0};
    tbl[2]  = '{"req030_b",  10'd300, 10'd0,   10'd700, 1'b0, 3'b000, 2'd1, 1'b0};
    tbl[3]  = '{"req030_c",  10'd300, 10'd0,   10'd500, 1'b0, 3'b000, 2'd2, 1'b0};
    tbl[4]  = '{"req030_d",  10'd250, 10'd800, 10'd0,   1'b0, 3'b000, 2'd2, 1'b0};
    tbl[5]  = '{"dec_011",   10'd11,  10'd22,  10'd33,  1'b1, 3'b011, 2'd3, 1'b1};
    tbl[6]  = '{"dec_000",   10'd44,  10'd55,  10'd66,  1'b1, 3'b000, 2'd3, 1'b1};
    tbl[7]  = '{"dec_110",   10'd1,   10'd2,   10'd3,   1'b1, 3'b110, 2'd3, 1'b1};
    tbl[8]  = '{"dec_111",   10'd1023,10'd1023,10'd1023,1'b1, 3'b111, 2'd3, 1'b1};
    tbl[9]  = '{"dec_100",   10'd7,   10'd8,   10'd9,   1'b1, 3'b100, 2'd2, 1'b0};
    tbl[10] = '{"dec_010",   10'd0,   10'd0,   10'd0,   1'b1, 3'b010, 2'd1, 1'b0};

    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.res_ready   = 1'b0;
    bus_b.in_data   = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.res_ready = 1'b0;

    // Reset state, then in_ready rising on the first edge after release
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    check("reset.b_in_ready", 32'(bus_b.in_ready), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("release.in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      ovr_en  = tbl[i].ovr;
      ovr_val = tbl[i].dec;
      run_frame(tbl[i].name, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].cls, tbl[i].err, 0);
    end
    ovr_en = 1'b0;

    // Result held for 5 cycles with words offered; next word must land in feat_1
    run_frame("stall", 10'd123, 10'd456, 10'd789, 2'd0, 1'b0, 5);
    push_word(10'd777, n);
    check("after_stall.feat_1", 32'(bus.feat_1), 32'd777);
    check("after_stall.feat_2", 32'(bus.feat_2), 32'd456);
    push_word(10'd5, n);
    push_word(10'd0, n);
    finish_frame("after_stall", n, 10'd777, 2'd0, 1'b0, 0);

    // Randomized frames against the reference decoder
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      w1      = word_t'($urandom);
      w2      = word_t'($urandom);
      w3      = word_t'($urandom);
      ovr_en  = ($urandom_range(0, 2) == 0);
      ovr_val = 3'($urandom);
      if (ovr_en) ref_decode(ovr_val, ecls, eerr);
      else        ref_decode(3'b001 << classify(w1, w2, w3), ecls, eerr);
      run_frame($sformatf("rand%0d", i), w1, w2, w3, ecls, eerr, $urandom_range(0, 3));
    end
    ovr_en = 1'b0;

    // Counter preset near the top, then two frames across the wrap
    @(negedge CLK);
    force dut.frame_cnt_q = 16'hfffe;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 65534;
    @(negedge CLK);
    check("wrap.preset", 32'(bus.frame_cnt), 32'd65534);
    run_frame("wrap_a", 10'd400, 10'd0, 10'd0, 2'd1, 1'b0, 0);
    run_frame("wrap_b", 10'd200, 10'd100, 10'd0, 2'd0, 1'b0, 0);
    check("wrap.zero", 32'(bus.frame_cnt), 32'd0);

    // Reset after two words: asynchronous clear, partial frame discarded
    run_frame("pre_reset", 10'd250, 10'd800, 10'd0, 2'd2, 1'b0, 0);
    push_word(10'd300, n);
    push_word(10'd400, n);
    #2;
    RST = 1'b0;
    #1;
    check("midframe_reset.feat_2", 32'(bus.feat_2), 32'd0);
    check("midframe_reset.in_ready", 32'(bus.in_ready), 32'd0);
    check("midframe_reset.res_class", 32'(bus.res_class), 32'd0);
    check("midframe_reset.frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    exp_cnt = 0;
    @(negedge CLK);
    run_frame("post_reset", 10'd200, 10'd100, 10'd0, 2'd0, 1'b0, 0);
    check("post_reset.cnt_one", 32'(bus.frame_cnt), 32'd1);

    // Reset while a result is pending
    ovr_en  = 1'b1;
    ovr_val = 3'b100;
    push_word(10'd1, n);
    push_word(10'd2, n);
    push_word(10'd3, n);
    k = 0;
    while (!bus.res_valid && k < BUDGET) begin
      @(negedge CLK);
      k++;
    end
    if (!bus.res_valid) timeout("midout.res_valid");
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs("midout_reset");
    @(negedge CLK);
    RST = 1'b1;
    ovr_en  = 1'b0;
    exp_cnt = 0;
    @(negedge CLK);
    run_frame("post_midout", 10'd200, 10'd100, 10'd0, 2'd0, 1'b0, 0);

    // EVAL_LAT=4 instance: result must rise four edges after the last accept
    wb[0] = 10'd200;
    wb[1] = 10'd100;
    wb[2] = 10'd0;
    nb = 0;
    for (int j = 0; j < 3; j++) begin
      bus_b.in_data  = wb[j];
      bus_b.in_valid = 1'b1;
      k = 0;
      while (!bus_b.in_ready && k < BUDGET) begin
        @(negedge CLK);
        k++;
      end
      if (!bus_b.in_ready) begin
        timeout("lat4.push");
      end else begin
        @(posedge CLK);
        @(negedge CLK);
        nb = cyc;
      end
      bus_b.in_valid = 1'b0;
    end
    k = 0;
    while (!bus_b.res_valid && k < BUDGET) begin
      @(negedge CLK);
      k++;
    end
    if (!bus_b.res_valid) begin
      timeout("lat4.res_valid");
    end else begin
      check("lat4.latency", 32'(cyc - nb), 32'(LAT_B));
      check("lat4.res_class", 32'(bus_b.res_class), 32'd0);
      check("lat4.res_err", 32'(bus_b.res_err), 32'd0);
      bus_b.res_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      bus_b.res_ready = 1'b0;
      check("lat4.frame_cnt", 32'(bus_b.frame_cnt), 32'd1);
      check("lat4.valid_drop", 32'(bus_b.res_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
